// File: rtl/huffman_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | huffman_decoder                                                          |
// | Canonical Huffman decoder: MSB-first serial code bits in, one symbol out |
// | per codeword. Optional HUFF_DEC_STATS_EN adds symbol/bit counters.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module huffman_decoder #(
    parameter int SYM_W   = 8,
    parameter int MAX_LEN = 12,
    parameter int NSYM    = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic                      cfg_sel,
    input  logic [$clog2(NSYM)-1:0]   cfg_addr,
    input  logic [((SYM_W > $clog2(NSYM)+1) ? SYM_W : $clog2(NSYM)+1)-1:0] cfg_data,
    input  logic                      in_bit,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [SYM_W-1:0]          out_sym,
    output logic [3:0]                out_len,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      err,
    output logic                      busy
`ifdef HUFF_DEC_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [31:0]               stat_syms,
    output logic [31:0]               stat_bits
`endif
);

    localparam int c_ADDR_W = $clog2(NSYM);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam int c_LW     = $clog2(MAX_LEN + 1);
    // Code/first arithmetic is wide enough that c - first never aliases.
    localparam int c_AW     = ((MAX_LEN > c_CNT_W) ? MAX_LEN : c_CNT_W) + 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_EMIT  = 2'd2;
    localparam logic [1:0] c_ST_ERR   = 2'd3;

    logic [c_CNT_W-1:0] r_cnt     [0:MAX_LEN];
    logic [SYM_W-1:0]   r_sym_mem [0:NSYM-1];

    logic [1:0]         r_state;
    logic               r_rdy_en;
    logic [c_AW-2:0]    r_code;
    logic [c_AW-1:0]    r_first;
    logic [c_CNT_W-1:0] r_index;
    logic [c_LW-1:0]    r_len;

    logic               w_accept;
    logic               w_hs;
    logic [c_LW-1:0]    w_len_inc;
    logic [c_AW-1:0]    w_code;
    logic [c_CNT_W-1:0] w_cnt;
    logic [c_AW-1:0]    w_off;
    logic               w_hit;
    logic               w_last;
    logic [c_ADDR_W-1:0] w_sym_addr;
    logic               w_cnt_wr_ok;

    // Held-off only during reset recovery, the error cycle, and a stalled symbol.
    assign in_ready   = r_rdy_en && (!out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_hs       = out_valid && out_ready;

    assign w_len_inc  = r_len + c_LW'(1);
    assign w_code     = {r_code, in_bit};
    assign w_cnt      = r_cnt[w_len_inc];
    assign w_off      = w_code - r_first;
    assign w_hit      = (w_off < c_AW'(w_cnt));
    assign w_last     = (w_len_inc == c_LW'(MAX_LEN));
    assign w_sym_addr = r_index[c_ADDR_W-1:0] + w_off[c_ADDR_W-1:0];

    assign w_cnt_wr_ok = (cfg_addr != '0) && (cfg_addr <= c_ADDR_W'(MAX_LEN));

    // Table storage is not reset; it is only writable while nothing is in flight.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            if (cfg_sel) begin
                r_sym_mem[cfg_addr] <= cfg_data[SYM_W-1:0];
            end else if (w_cnt_wr_ok) begin
                r_cnt[cfg_addr[c_LW-1:0]] <= cfg_data[c_CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_rdy_en  <= 1'b0;
            r_code    <= '0;
            r_first   <= '0;
            r_index   <= '0;
            r_len     <= '0;
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_len   <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            err      <= 1'b0;
            case (r_state)
                c_ST_ERR: begin
                    r_state <= c_ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    if (w_hs) begin
                        out_valid <= 1'b0;
                    end
                    if (w_accept) begin
                        if (w_hit) begin
                            out_sym   <= r_sym_mem[w_sym_addr];
                            out_len   <= 4'(w_len_inc);
                            out_valid <= 1'b1;
                            r_code    <= '0;
                            r_first   <= '0;
                            r_index   <= '0;
                            r_len     <= '0;
                            r_state   <= c_ST_EMIT;
                            busy      <= 1'b1;
                        end else if (w_last) begin
                            r_code    <= '0;
                            r_first   <= '0;
                            r_index   <= '0;
                            r_len     <= '0;
                            r_state   <= c_ST_ERR;
                            r_rdy_en  <= 1'b0;
                            err       <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            r_code    <= w_code[c_AW-2:0];
                            r_first   <= (r_first + c_AW'(w_cnt)) << 1;
                            r_index   <= r_index + w_cnt;
                            r_len     <= w_len_inc;
                            r_state   <= c_ST_ACCUM;
                            busy      <= 1'b1;
                        end
                    end else if (w_hs) begin
                        r_state <= c_ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef HUFF_DEC_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_syms <= '0;
            stat_bits <= '0;
        end else if (stat_clr) begin
            stat_syms <= '0;
            stat_bits <= '0;
        end else begin
            if (w_hs && (stat_syms != '1)) begin
                stat_syms <= stat_syms + 32'd1;
            end
            if (w_accept && (stat_bits != '1)) begin
                stat_bits <= stat_bits + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_huffman_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_huffman_decoder                                                       |
// | Scoreboard bench for huffman_decoder (HUFF_DEC_STATS_EN adds stats test).|
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic       cfg_sel = 1'b0;
    logic [7:0] cfg_addr = '0;
    logic [8:0] cfg_data = '0;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       out_valid;
    logic       err;
    logic       busy;
    logic [7:0] out_sym;
    logic [3:0] out_len;
`ifdef HUFF_DEC_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_syms;
    logic [31:0] stat_bits;
`endif

    typedef struct {
        logic [7:0] sym;
        logic [3:0] len;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   first_acc = 0;
    int   err_cnt = 0;
    int   ov_cnt = 0;
    bit   mark_first = 1'b0;
    bit   head_seen = 1'b0;

    huffman_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sym   (out_sym),
        .out_len   (out_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .busy      (busy)
`ifdef HUFF_DEC_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_syms (stat_syms),
        .stat_bits (stat_bits)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: arrival cycle checked once per symbol, value at handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (err) err_cnt++;
            if (out_valid) begin
                ov_cnt++;
                if (sb.size() == 0) begin
                    if (out_ready) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_sym: got sym %02h len %0d, none expected", out_sym, out_len);
                    end
                end else begin
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        n_cmp++;
                        if (cyc !== sb[0].due) begin
                            n_bad++;
                            $display("FAIL latency_%02h: out_valid in cycle %0d, expected cycle %0d", sb[0].sym, cyc, sb[0].due);
                        end
                    end
                    if (out_ready) begin
                        n_cmp++;
                        if (out_sym !== sb[0].sym || out_len !== sb[0].len) begin
                            n_bad++;
                            $display("FAIL sym_%02h: got sym %02h len %0d, expected sym %02h len %0d", sb[0].sym, out_sym, out_len, sb[0].sym, sb[0].len);
                        end
                        void'(sb.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic sel, input logic [7:0] addr, input logic [8:0] data);
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        cfg_we   = 1'b1;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic load_counts(input int c1, input int c2, input int c3);
        for (int l = 1; l <= 12; l++) begin
            cfg_write(1'b0, 8'(l), (l == 1) ? 9'(c1) : (l == 2) ? 9'(c2) : (l == 3) ? 9'(c3) : 9'd0);
        end
    endtask

    task automatic load_std();
        load_counts(0, 3, 2);
        for (int i = 0; i < 5; i++) cfg_write(1'b1, 8'(i), 9'(8'h41 + i));
    endtask

    task automatic send_bit(input logic b);
        int t = 0;
        bit ok = 1'b0;
        in_bit   = b;
        in_valid = 1'b1;
        while (!ok && t < 50) begin
            @(negedge clk);
            if (in_ready === 1'b1) ok = 1'b1;
            else t++;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bit_accept: in_ready %b after %0d cycles, expected 1", in_ready, t);
        end
        last_acc = cyc;
        if (mark_first) begin
            first_acc  = cyc;
            mark_first = 1'b0;
        end
        step();
    endtask

    task automatic send_code(input logic [11:0] code, input int nb, input logic [7:0] sym);
        for (int i = nb - 1; i >= 0; i--) send_bit(code[i]);
        sb.push_back('{sym, 4'(nb), last_acc + 1});
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d symbols still pending, expected 0", sb.size());
            sb.delete();
        end
        head_seen = 1'b0;
        step();
    endtask

    task automatic stream_five();
        send_code(12'b00,  2, 8'h41);
        send_code(12'b01,  2, 8'h42);
        send_code(12'b10,  2, 8'h43);
        send_code(12'b110, 3, 8'h44);
        send_code(12'b111, 3, 8'h45);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
        n_cmp++; if (out_sym !== 8'h00)  begin n_bad++; $display("FAIL rst_out_sym: got %02h, expected 00", out_sym); end
        n_cmp++; if (out_len !== 4'd0)   begin n_bad++; $display("FAIL rst_out_len: got %0d, expected 0", out_len); end
        n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL rst_err: got %b, expected 0", err); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_rst_idle: in_ready %b busy %b, expected 1 0", in_ready, busy);
        end
        step();
    endtask

    task automatic test_stream();
        out_ready  = 1'b1;
        mark_first = 1'b1;
        stream_five();
        n_cmp++;
        if (last_acc - first_acc !== 11) begin
            n_bad++;
            $display("FAIL stream_bubbles: 12 bits took %0d cycles, expected 12", last_acc - first_acc + 1);
        end
        drain();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stream_idle: busy %b out_valid %b in_ready %b, expected 0 0 1", busy, out_valid, in_ready);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_code(12'b00, 2, 8'h41);
        in_bit   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_sym !== 8'h41 || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_%0d: out_valid %b sym %02h in_ready %b busy %b, expected 1 41 0 1", i, out_valid, out_sym, in_ready, busy);
            end
            step();
        end
        out_ready = 1'b1;
        send_code(12'b01,  2, 8'h42);
        send_code(12'b111, 3, 8'h45);
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_error();
        int e0;
        int v0;
        load_counts(1, 0, 0);
        cfg_write(1'b1, 8'd0, 9'h07F);
        e0 = err_cnt;
        v0 = ov_cnt;
        for (int i = 0; i < 12; i++) send_bit(1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pulse: err %b in_ready %b busy %b, expected 1 0 0", err, in_ready, busy);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL err_recover: err %b in_ready %b, expected 0 1", err, in_ready);
        end
        step();
        n_cmp++;
        if (err_cnt - e0 !== 1 || ov_cnt !== v0) begin
            n_bad++;
            $display("FAIL err_count: err cycles %0d out_valid cycles %0d, expected 1 0", err_cnt - e0, ov_cnt - v0);
        end
        send_code(12'b0, 1, 8'h7F);
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        send_bit(1'b1);
        send_bit(1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b, expected 1", busy); end
        step();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst: in_ready %b busy %b out_valid %b, expected 0 0 0", in_ready, busy, out_valid);
        end
        step();
        rst = 1'b0;
        step();
        send_code(12'b111, 3, 8'h45);
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_cfg_busy();
        send_bit(1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL cfg_busy_pre: busy %b, expected 1", busy); end
        step();
        cfg_write(1'b0, 8'd2, 9'd0);
        cfg_write(1'b1, 8'd4, 9'h0AA);
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL cfg_busy_err: err %b busy %b, expected 0 1", err, busy);
        end
        step();
        send_bit(1'b1);
        send_bit(1'b0);
        sb.push_back('{8'h44, 4'd3, last_acc + 1});
        send_code(12'b00,  2, 8'h41);
        send_code(12'b01,  2, 8'h42);
        send_code(12'b10,  2, 8'h43);
        send_code(12'b111, 3, 8'h45);
        in_valid = 1'b0;
        drain();
    endtask

`ifdef HUFF_DEC_STATS_EN
    task automatic test_stats();
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        stream_five();
        drain();
        @(negedge clk);
        n_cmp++;
        if (stat_syms !== 32'd5 || stat_bits !== 32'd12) begin
            n_bad++;
            $display("FAIL stats_count: syms %0d bits %0d, expected 5 12", stat_syms, stat_bits);
        end
        step();
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stat_syms !== 32'd0 || stat_bits !== 32'd0) begin
            n_bad++;
            $display("FAIL stats_clr: syms %0d bits %0d, expected 0 0", stat_syms, stat_bits);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        load_std();
        test_stream();
        test_backpressure();
        test_error();
        load_std();
        test_reset_mid();
        test_cfg_busy();
`ifdef HUFF_DEC_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
